// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: state encoding and default payload width.
// No logic; types and constants only.
// Imported by every pipeline-stage module.
package pipe_pkg;

  // Default payload: 1+1+32+32+5 write-back bundle.
  localparam int PIPE_WIDTH = 71;

  // Entries held by a skid stage; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear (clear wins over load).
// Latency: one cycle from load_i/clear_i to q_o.
// Backpressure: none; the owner decides when to load.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Hold the payload; async reset and sync clear both zero it.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      data_q <= '0;
    end else if (clear_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Registered pipeline stage with one skid entry; breaks the ready path.
// Latency: one cycle from accepted input to Out_valid.
// Backpressure: In_ready decodes registered state only (low when both entries hold data).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH          = PIPE_WIDTH,
  parameter int ZERO_INVALID   = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_data,
  input  logic             Flush,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out_data,
  output logic [1:0]       Occupancy
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_ld, skid_ld, main_clr, skid_clr;
  logic             in_fire, out_fire;

  assign In_ready  = (state_q != ST_FULL);
  assign Out_valid = (state_q != ST_EMPTY);
  assign Occupancy = state_q;
  assign in_fire   = In_valid & In_ready;
  assign out_fire  = Out_valid & Out_ready;

  // Main refills from skid when draining a full stage, otherwise from upstream.
  assign main_d = (state_q == ST_FULL) ? skid_q : In_data;

  assign Out_data = ((ZERO_INVALID != 0) && !Out_valid) ? '0 : main_q;

  // State register; reset discards any held beats.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and register enables; flush overrides any handshake in its cycle.
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_clr = 1'b0;
    skid_clr = 1'b0;
    if (Flush) begin
      state_d  = ST_EMPTY;
      main_clr = (CLEAR_ON_FLUSH != 0);
      skid_clr = (CLEAR_ON_FLUSH != 0);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .load_i  (main_ld),
    .clear_i (main_clr),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .load_i  (skid_ld),
    .clear_i (skid_clr),
    .d_i     (In_data),
    .q_o     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: Out_ready driven directly and randomly.
module tb_pipe_skid_reg;

  localparam int W = 71;

  logic         Clk = 1'b0;
  logic         Clrn;
  logic         In_valid, In_ready, Flush, Out_valid, Out_ready;
  logic [W-1:0] In_data, Out_data;
  logic [1:0]   Occupancy;

  logic         b_In_valid, b_In_ready, b_Flush, b_Out_valid, b_Out_ready;
  logic [W-1:0] b_In_data, b_Out_data;
  logic [1:0]   b_Occupancy;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mq[$];

  always #5 Clk = ~Clk;

  pipe_skid_reg #(.WIDTH(W), .ZERO_INVALID(1), .CLEAR_ON_FLUSH(1)) dut (
    .Clk(Clk), .Clrn(Clrn), .In_valid(In_valid), .In_ready(In_ready),
    .In_data(In_data), .Flush(Flush), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Out_data(Out_data), .Occupancy(Occupancy)
  );

  pipe_skid_reg #(.WIDTH(W), .ZERO_INVALID(0), .CLEAR_ON_FLUSH(0)) dut_b (
    .Clk(Clk), .Clrn(Clrn), .In_valid(b_In_valid), .In_ready(b_In_ready),
    .In_data(b_In_data), .Flush(b_Flush), .Out_valid(b_Out_valid),
    .Out_ready(b_Out_ready), .Out_data(b_Out_data), .Occupancy(b_Occupancy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Compare every output against the FIFO-of-beats model.
  task automatic check_model(input string tag);
    logic [W-1:0] exp_dat;
    exp_dat = (mq.size() > 0) ? mq[0] : '0;
    check({tag, "_in_ready"},  W'(In_ready),  W'(mq.size() < 2));
    check({tag, "_out_valid"}, W'(Out_valid), W'(mq.size() > 0));
    check({tag, "_out_data"},  Out_data,      exp_dat);
    check({tag, "_occupancy"}, W'(Occupancy), W'(mq.size()));
  endtask

  // One clock of traffic: drive, advance model at the edge, check after it.
  task automatic cycle(input string tag, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic fl,
                       output bit in_f, output bit out_f, output logic [W-1:0] od);
    In_valid  = iv;
    In_data   = id;
    Out_ready = ordy;
    Flush     = fl;
    in_f  = iv && (mq.size() < 2);
    out_f = ordy && (mq.size() > 0);
    od    = Out_data;
    @(posedge Clk);
    if (fl) begin
      mq.delete();
      in_f  = 1'b0;
      out_f = 1'b0;
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(id);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    bit           inf, outf;
    logic [W-1:0] od;
    int           tx, rx;

    Clrn = 1'b0; In_valid = 1'b0; In_data = '0; Flush = 1'b0; Out_ready = 1'b0;
    b_In_valid = 1'b0; b_In_data = '0; b_Flush = 1'b0; b_Out_ready = 1'b0;

    // Reset values while Clrn is low.
    #3;
    check_model("in_rst");
    #9 Clrn = 1'b1;
    @(posedge Clk);
    #1;
    check_model("post_rst");

    // Single beat, one-cycle latency.
    cycle("one", 1'b1, W'(1), 1'b1, 1'b0, inf, outf, od);
    check("one_valid", W'(Out_valid), W'(1));
    check("one_data",  Out_data,      W'(1));
    check("one_occ",   W'(Occupancy), W'(1));
    cycle("one_drain", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);

    // Fill both entries under backpressure, then drain in order.
    cycle("fill_a", 1'b1, W'('hA), 1'b0, 1'b0, inf, outf, od);
    cycle("fill_b", 1'b1, W'('hB), 1'b0, 1'b0, inf, outf, od);
    check("full_occ",   W'(Occupancy), W'(2));
    check("full_ready", W'(In_ready),  W'(0));
    check("full_head",  Out_data,      W'('hA));
    cycle("drain1", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);
    check("drain1_data", Out_data, W'('hB));
    cycle("drain2", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);
    check("drain2_valid", W'(Out_valid), W'(0));

    // Flush while full with a beat offered: everything gone, offered beat discarded.
    cycle("fl_a", 1'b1, W'('hA), 1'b0, 1'b0, inf, outf, od);
    cycle("fl_b", 1'b1, W'('hB), 1'b0, 1'b0, inf, outf, od);
    cycle("flush", 1'b1, W'('hC), 1'b0, 1'b1, inf, outf, od);
    check("flush_occ",   W'(Occupancy), W'(0));
    check("flush_valid", W'(Out_valid), W'(0));
    check("flush_data",  Out_data,      W'(0));
    for (int i = 0; i < 3; i++) cycle("post_flush", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);

    // Stream 0..99 with random valid/ready; receiver sees an unbroken count.
    tx = 0;
    rx = 0;
    for (int c = 0; c < 3000 && rx < 100; c++) begin
      cycle("stream", (tx < 100) && ($urandom_range(0, 3) != 0), W'(tx),
            1'($urandom_range(0, 1)), 1'b0, inf, outf, od);
      if (inf) tx++;
      if (outf) begin
        check("stream_order", od, W'(rx));
        rx++;
      end
    end
    check("stream_count", W'(rx), W'(100));

    // Random traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      cycle("rand", 1'($urandom_range(0, 1)), W'({$urandom(), $urandom(), $urandom()}),
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, inf, outf, od);
    end
    while (mq.size() > 0) cycle("rand_drain", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);

    // Reset pulsed mid-cycle while full: outputs drop before the next edge.
    cycle("rfill_a", 1'b1, W'('h11), 1'b0, 1'b0, inf, outf, od);
    cycle("rfill_b", 1'b1, W'('h22), 1'b0, 1'b0, inf, outf, od);
    In_valid = 1'b0;
    #2 Clrn = 1'b0;
    #1;
    check("arst_valid", W'(Out_valid), W'(0));
    check("arst_occ",   W'(Occupancy), W'(0));
    mq.delete();
    check_model("arst");
    #2 Clrn = 1'b1;
    cycle("arst_idle", 1'b0, '0, 1'b1, 1'b0, inf, outf, od);
    cycle("arst_new",  1'b1, W'(7), 1'b0, 1'b0, inf, outf, od);
    cycle("arst_out",  1'b0, '0, 1'b1, 1'b0, inf, outf, od);

    // No masking, no clear: flush invalidates but leaves data visible.
    b_In_valid = 1'b1;
    b_In_data  = W'(5);
    @(posedge Clk);
    #1;
    b_In_valid = 1'b0;
    check("b_load_valid", W'(b_Out_valid), W'(1));
    check("b_load_data",  b_Out_data,      W'(5));
    b_Flush = 1'b1;
    @(posedge Clk);
    #1;
    b_Flush = 1'b0;
    check("b_flush_valid", W'(b_Out_valid), W'(0));
    check("b_flush_data",  b_Out_data,      W'(5));
    check("b_flush_occ",   W'(b_Occupancy), W'(0));
    check("b_flush_ready", W'(b_In_ready),  W'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 71, giving data bits per stage (71 = 1+1+32+32+5 WB bundle).
REQ-002 SHALL have parameter ZERO_INVALID, default 1; when 1, Out_data reads 0 whenever Out_valid=0.
REQ-003 SHALL have parameter CLEAR_ON_FLUSH, default 1; when 1, Flush zeroes both data registers.
REQ-004 SHALL have port Clk, input, 1, the single clock; all state SHALL be updated on rising edge only.
REQ-005 SHALL have port Clrn, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port In_valid, input, 1, upstream data valid.
REQ-007 SHALL have port In_ready, output, 1, stage can accept.
REQ-008 SHALL have port In_data, input, WIDTH, upstream payload.
REQ-009 SHALL have port Flush, input, 1, synchronous pipeline flush.
REQ-010 SHALL have port Out_valid, output, 1, downstream data valid.
REQ-011 SHALL have port Out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port Out_data, output, WIDTH, payload to next stage.
REQ-013 SHALL have port Occupancy, output, 2, entries held (0..2).

Function
REQ-014 SHALL hold a main register and one skid register; state EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-015 SHALL define in_fire = In_valid & In_ready and out_fire = Out_valid & Out_ready, sampled at the rising edge.
REQ-016 SHALL drive In_ready = (state != FULL), a decode of registered state only, with no combinational path from Out_ready.
REQ-017 SHALL drive Out_valid = (state != EMPTY) and Out_data = main register (masked per REQ-002).
REQ-018 SHALL, in EMPTY: in_fire -> main<=In_data, go ONE; otherwise stay.
REQ-019 SHALL, in ONE: in_fire&out_fire -> main<=In_data, stay ONE; in_fire only -> skid<=In_data, go FULL; out_fire only -> go EMPTY; neither -> hold.
REQ-020 SHALL, in FULL: out_fire -> main<=skid, go ONE; otherwise hold; In_data ignored.
REQ-021 SHALL give latency of exactly one cycle from in_fire into EMPTY to Out_valid=1.
REQ-022 SHALL, when Flush=1, go EMPTY at the next edge regardless of in_fire/out_fire in that cycle; the input beat of that cycle is discarded.
REQ-023 SHALL zero main and skid on Flush when CLEAR_ON_FLUSH=1 and leave them unchanged otherwise.
REQ-024 SHALL report Occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-025 SHALL never drop or duplicate a beat: accepted beats SHALL leave in acceptance order absent Flush.
REQ-026 SHALL hold Out_data stable while Out_valid=1 and Out_ready=0.

Reset
REQ-027 SHALL, while Clrn=0, force state EMPTY, main=0, skid=0, independent of Clk.
REQ-028 SHALL therefore output Out_valid=0, Out_data=0, Occupancy=0, In_ready=1 during and immediately after reset.
REQ-029 SHALL, on reset asserted mid-transfer, discard all held beats; first edge after release behaves as EMPTY.

Structure
REQ-030 SHALL take the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default WIDTH from shared package pipe_pkg.
REQ-031 SHALL instantiate sub-module pipe_data_reg (WIDTH-wide register with load enable, sync clear, async active-low reset) twice, for main and skid.

Verification
REQ-032 SHALL cover: reset release, In_valid=1 In_data=0x1 with Out_ready=1 -> Out_valid=1 Out_data=0x1 next cycle, Occupancy=1.
REQ-033 SHALL cover: Out_ready=0, send 0xA then 0xB -> Occupancy=2, In_ready=0; raise Out_ready -> outputs 0xA then 0xB on consecutive cycles.
REQ-034 SHALL cover: FULL holding 0xA,0xB, Flush=1 with In_valid=1 In_data=0xC -> next cycle Occupancy=0, Out_valid=0, Out_data=0, 0xC never appears.
REQ-035 SHALL cover: streaming 0..99 with Out_ready toggling pseudo-randomly -> downstream receives exactly 0..99 in order, no gaps.
REQ-036 SHALL cover: Clrn pulsed low mid-cycle while FULL -> Out_valid and Occupancy drop to 0 immediately, before the next Clk edge.
REQ-037 SHALL cover: ZERO_INVALID=0, CLEAR_ON_FLUSH=0, flush while holding 0x5 -> Out_valid=0 and Out_data stays 0x5.
